// File: rtl/tlctrl_nphase.sv
// Purpose : N-phase traffic-light controller cycling GREEN -> YELLOW -> ALL-RED per phase,
//           skipping phases with no demand (all phases rotate when nobody requests).
// Latency : lamps, phase and counter are registered; o_phase_done is combinational from state.
// Flow    : i_en low freezes state, phase and counter. No other stall path.
// Ports   : i_clk/i_rst (sync, active-high), i_en, i_green_time (per-phase green length),
//           i_req (per-phase demand), o_phase, o_green/o_yellow (one-hot lamps),
//           o_remaining (cycles left in interval minus 1), o_phase_done.
// Option  : TLCTRL_FLASH_EN adds i_flash and a FLASH state blinking all yellows every Y_TIME cycles.
module tlctrl_nphase #(
    parameter int T_WIDTH  = 8,
    parameter int N_PHASES = 4,
    parameter int Y_TIME   = 3,
    parameter int AR_TIME  = 1,
    localparam int PW      = (N_PHASES > 2) ? $clog2(N_PHASES) : 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_en,
`ifdef TLCTRL_FLASH_EN
    input  logic                          i_flash,
`endif
    input  logic [N_PHASES*T_WIDTH-1:0]   i_green_time,
    input  logic [N_PHASES-1:0]           i_req,
    output logic [PW-1:0]                 o_phase,
    output logic [N_PHASES-1:0]           o_green,
    output logic [N_PHASES-1:0]           o_yellow,
    output logic [T_WIDTH-1:0]            o_remaining,
    output logic                          o_phase_done
);

    typedef enum logic [2:0] {
        S_START  = 3'd0,
        S_GREEN  = 3'd1,
        S_YELLOW = 3'd2,
        S_ALLRED = 3'd3
`ifdef TLCTRL_FLASH_EN
        ,S_FLASH = 3'd4
`endif
    } state_t;

    // Durations are truncated to the counter width first; a zero duration still lasts one cycle.
    localparam logic [T_WIDTH-1:0] Y_D   = T_WIDTH'(Y_TIME);
    localparam logic [T_WIDTH-1:0] AR_D  = T_WIDTH'(AR_TIME);
    localparam logic [T_WIDTH-1:0] LD_Y  = (Y_D  == '0) ? '0 : Y_D  - 1'b1;
    localparam logic [T_WIDTH-1:0] LD_AR = (AR_D == '0) ? '0 : AR_D - 1'b1;

    function automatic logic [T_WIDTH-1:0] load_of(input logic [T_WIDTH-1:0] d);
        return (d == '0) ? '0 : d - 1'b1;
    endfunction

    // First candidate found searching upward (with wrap) from index 'from'.
    // An idle request bus makes every phase a candidate.
    function automatic logic [PW-1:0] pick(input int from, input logic [N_PHASES-1:0] req);
        logic [N_PHASES-1:0] cand;
        logic                found;
        logic [PW-1:0]       res;
        int                  idx;
        cand  = (req == '0) ? '1 : req;
        found = 1'b0;
        res   = '0;
        for (int i = 0; i < N_PHASES; i++) begin
            idx = (from + i) % N_PHASES;
            if (!found && |(cand & (N_PHASES'(1) << idx))) begin
                res   = PW'(idx);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    state_t              state_q, state_d;
    logic [PW-1:0]       phase_q, phase_d;
    logic [T_WIDTH-1:0]  cnt_q, cnt_d;
`ifdef TLCTRL_FLASH_EN
    logic                flash_on_q, flash_on_d;
`endif

    logic [PW-1:0]       start_pick, rot_pick;
    logic [T_WIDTH-1:0]  start_ld, rot_ld;

    // Starting the search at phase+1 leaves the current phase for last, so a lone requester repeats.
    assign start_pick = pick(0, i_req);
    assign rot_pick   = pick((int'(phase_q) + 1) % N_PHASES, i_req);
    assign start_ld   = load_of(i_green_time[int'(start_pick)*T_WIDTH +: T_WIDTH]);
    assign rot_ld     = load_of(i_green_time[int'(rot_pick)*T_WIDTH +: T_WIDTH]);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
`ifdef TLCTRL_FLASH_EN
        flash_on_d = flash_on_q;
        if (i_flash) begin
            if (state_q != S_FLASH) begin
                state_d    = S_FLASH;
                cnt_d      = LD_Y;
                flash_on_d = 1'b1;
            end else if (cnt_q == '0) begin
                cnt_d      = LD_Y;
                flash_on_d = ~flash_on_q;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end else if (state_q == S_FLASH) begin
            state_d = S_START;
            phase_d = '0;
            cnt_d   = LD_Y;
        end else
`endif
        begin
            case (state_q)
                S_START, S_GREEN, S_YELLOW, S_ALLRED: begin
                    if (i_en) begin
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - 1'b1;
                        end else begin
                            case (state_q)
                                S_START: begin
                                    state_d = S_GREEN;
                                    phase_d = start_pick;
                                    cnt_d   = start_ld;
                                end
                                S_GREEN: begin
                                    state_d = S_YELLOW;
                                    cnt_d   = LD_Y;
                                end
                                S_YELLOW: begin
                                    state_d = S_ALLRED;
                                    cnt_d   = LD_AR;
                                end
                                default: begin
                                    state_d = S_GREEN;
                                    phase_d = rot_pick;
                                    cnt_d   = rot_ld;
                                end
                            endcase
                        end
                    end
                end
                default: begin
                    state_d = S_START;
                    phase_d = '0;
                    cnt_d   = LD_Y;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_START;
            phase_q <= '0;
            cnt_q   <= LD_Y;
`ifdef TLCTRL_FLASH_EN
            flash_on_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
`ifdef TLCTRL_FLASH_EN
            flash_on_q <= flash_on_d;
`endif
        end
    end

    logic [N_PHASES-1:0] phase_oh;
    logic                done_ok;

    assign phase_oh = N_PHASES'(1) << phase_q;
`ifdef TLCTRL_FLASH_EN
    assign done_ok  = i_en && !i_flash;
    assign o_yellow = (state_q == S_YELLOW) ? phase_oh :
                      (state_q == S_FLASH)  ? {N_PHASES{flash_on_q}} : '0;
`else
    assign done_ok  = i_en;
    assign o_yellow = (state_q == S_YELLOW) ? phase_oh : '0;
`endif
    assign o_green      = (state_q == S_GREEN) ? phase_oh : '0;
    assign o_phase      = phase_q;
    assign o_remaining  = cnt_q;
    assign o_phase_done = (state_q == S_ALLRED) && (cnt_q == '0) && done_ok;

endmodule

// File: tb/tb_tlctrl_nphase.sv
module tb_tlctrl_nphase;
    localparam int NP = 4;
    localparam int TW = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en  = 1'b1;
    logic [NP*TW-1:0] gt  = {NP{8'd5}};
    logic [NP-1:0]    req = '0;
`ifdef TLCTRL_FLASH_EN
    logic             flash = 1'b0;
`endif
    logic [1:0]       o_phase;
    logic [NP-1:0]    o_green, o_yellow;
    logic [TW-1:0]    o_remaining;
    logic             o_phase_done;

    tlctrl_nphase dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
`ifdef TLCTRL_FLASH_EN
        .i_flash      (flash),
`endif
        .i_green_time (gt),
        .i_req        (req),
        .o_phase      (o_phase),
        .o_green      (o_green),
        .o_yellow     (o_yellow),
        .o_remaining  (o_remaining),
        .o_phase_done (o_phase_done)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: which interval we are in (0 start, 1 green, 2 yellow, 3 all-red),
    // the phase, and how many cycles of the interval are still to run (D down to 1).
    bit model_valid = 1'b0;
    int m_int   = 0;
    int m_phase = 0;
    int m_left  = 3;

    function automatic int pick(input int from, input logic [NP-1:0] r);
        logic [NP-1:0] c;
        c = (r == '0) ? '1 : r;
        for (int i = 0; i < NP; i++)
            if (c[(from + i) % NP]) return (from + i) % NP;
        return 0;
    endfunction

    function automatic int green_len(input logic [NP*TW-1:0] g, input int p);
        int d;
        d = int'(g[p*TW +: TW]);
        return (d == 0) ? 1 : d;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_int = 0; m_phase = 0; m_left = 3;
            model_valid = 1'b1;
        end else if (en) begin
            if (m_left > 1) begin
                m_left--;
            end else begin
                case (m_int)
                    0: begin m_int = 1; m_phase = pick(0, req); m_left = green_len(gt, m_phase); end
                    1: begin m_int = 2; m_left = 3; end
                    2: begin m_int = 3; m_left = 1; end
                    default: begin m_int = 1; m_phase = pick(m_phase + 1, req); m_left = green_len(gt, m_phase); end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk("phase",     32'(o_phase),      32'(m_phase));
            chk("green",     32'(o_green),      (m_int == 1) ? (32'd1 << m_phase) : 32'd0);
            chk("yellow",    32'(o_yellow),     (m_int == 2) ? (32'd1 << m_phase) : 32'd0);
            chk("remaining", 32'(o_remaining),  32'(m_left - 1));
            chk("done",      32'(o_phase_done), 32'((m_int == 3 && m_left == 1 && en) ? 1 : 0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    int seq[8];
    int nseq, bad, dones, n;
    logic [NP-1:0] prev, held;

    task automatic collect(input int cycles);
        nseq = 0; bad = 0; prev = '0;
        for (int c = 0; c < cycles; c++) begin
            tick();
            if ((o_green & ~req) != '0) bad++;
            if (o_green != '0 && prev == '0 && nseq < 8) begin
                seq[nseq] = int'(o_phase);
                nseq++;
            end
            prev = o_green;
        end
    endtask

    initial begin
        // Fixed-time rotation with every green = 5.
        do_reset();
        dones = 0;
        for (int c = 1; c <= 39; c++) begin
            tick();
            if (c >= 3 && c <= 38) dones += int'(o_phase_done);
            if (c == 1)  chk("start_rem1",   32'(o_remaining), 32'd1);
            if (c == 2)  chk("start_rem0",   32'(o_remaining), 32'd0);
            if (c == 2)  chk("start_lamps",  32'(o_green | o_yellow), 32'd0);
            if (c == 3)  chk("g0_entry",     32'(o_green), 32'd1);
            if (c == 3)  chk("g0_rem",       32'(o_remaining), 32'd4);
            if (c == 7)  chk("g0_last",      32'(o_green), 32'd1);
            if (c == 8)  chk("y0_entry",     32'(o_yellow), 32'd1);
            if (c == 11) chk("ar_done",      32'(o_phase_done), 32'd1);
            if (c == 11) chk("ar_lamps",     32'(o_green | o_yellow), 32'd0);
            if (c == 12) chk("g1_entry",     32'(o_green), 32'd2);
            if (c == 38) chk("pre_rot_lamps", 32'(o_green), 32'd0);
            if (c == 39) chk("rotation_g0",  32'(o_green), 32'd1);
        end
        chk("done_pulses", 32'(dones), 32'd4);

        // Demand on phases 0 and 2 only.
        req = 4'b0101;
        do_reset();
        collect(80);
        chk("skip_nseq", 32'(nseq >= 4), 32'd1);
        chk("skip_seq0", 32'(seq[0]), 32'd0);
        chk("skip_seq1", 32'(seq[1]), 32'd2);
        chk("skip_seq2", 32'(seq[2]), 32'd0);
        chk("skip_seq3", 32'(seq[3]), 32'd2);
        chk("skip_bad",  32'(bad), 32'd0);

        // Single requester repeats.
        req = 4'b0010;
        do_reset();
        collect(40);
        chk("single_nseq", 32'(nseq >= 3), 32'd1);
        chk("single_seq0", 32'(seq[0]), 32'd1);
        chk("single_seq1", 32'(seq[1]), 32'd1);
        chk("single_seq2", 32'(seq[2]), 32'd1);

        // Zero green time on phase 0 lasts one cycle.
        req = '0;
        gt  = {8'd5, 8'd5, 8'd5, 8'd0};
        do_reset();
        n = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (o_green == 4'b0001) n++;
        end
        chk("g0_zero_len", 32'(n), 32'd1);

        // Freeze mid-green at remaining = 2.
        gt = {NP{8'd5}};
        do_reset();
        n = 0;
        while (!(o_green != '0 && o_remaining == 8'd2) && n < 20) begin tick(); n++; end
        chk("wait_g_rem2", 32'(n < 20), 32'd1);
        en = 1'b0;
        held = o_green;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("frozen_rem",   32'(o_remaining), 32'd2);
            chk("frozen_green", 32'(o_green), 32'(held));
        end
        en = 1'b1;
        n = 0;
        while (o_green != '0 && n < 20) begin n++; tick(); end
        chk("green_after_en", 32'(n), 32'd3);

        // Reset pulse while phase 2 is yellow.
        do_reset();
        n = 0;
        while (o_yellow != 4'b0100 && n < 60) begin tick(); n++; end
        chk("wait_y2", 32'(n < 60), 32'd1);
        rst = 1'b1;
        tick();
        chk("rst_phase", 32'(o_phase), 32'd0);
        chk("rst_lamps", 32'(o_green | o_yellow), 32'd0);
        chk("rst_rem",   32'(o_remaining), 32'd2);
        chk("rst_done",  32'(o_phase_done), 32'd0);
        rst = 1'b0;

        // Random traffic checked by the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) req = NP'($urandom);
            if ($urandom_range(0, 31) == 0)
                for (int k = 0; k < NP; k++) gt[k*TW +: TW] = TW'($urandom_range(0, 6));
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        en  = 1'b1;

`ifdef TLCTRL_FLASH_EN
        req = '0;
        gt  = {NP{8'd5}};
        do_reset();
        n = 0;
        while (o_green != 4'b0010 && n < 40) begin tick(); n++; end
        chk("wait_g1", 32'(n < 40), 32'd1);
        model_valid = 1'b0;
        flash = 1'b1;
        for (int c = 0; c < 7; c++) begin
            tick();
            chk("flash_yellow", 32'(o_yellow), (c < 3 || c == 6) ? 32'hF : 32'h0);
            chk("flash_green",  32'(o_green), 32'd0);
        end
        flash = 1'b0;
        tick();
        chk("unflash_lamps", 32'(o_green | o_yellow), 32'd0);
        chk("unflash_phase", 32'(o_phase), 32'd0);
        n = 0;
        while (o_green == '0 && n < 10) begin tick(); n++; end
        chk("unflash_g0", 32'(o_green), 32'd1);
`endif

        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
